// File: rtl/shift_seq_pkg.sv
// Shared types and default widths for the multi-bit shift sequencer.
// Used by shift_step and shift_sequencer (optional feature macro: SHIFT_EARLY_ZERO_EN).
package shift_seq_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_AMT_W  = 4;

    typedef enum logic [1:0] {
        SH_PASS = 2'b00,
        SH_LSL  = 2'b01,
        SH_LSR  = 2'b10,
        SH_ROR  = 2'b11
    } shift_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    // Zero-filling ops are the only ones whose result can collapse to zero early.
    function automatic logic is_zero_fill(input shift_op_t op);
        return (op == SH_LSL) || (op == SH_LSR);
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift unit: pass, shift left, logical shift right,
// rotate right by one, selected per output bit.
module shift_step
    import shift_seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] d,
    input  shift_op_t         op,
    output logic [DATA_W-1:0] q
);

    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_bit
            logic shl_bit;
            logic lsr_bit;
            logic ror_bit;

            if (gi == 0) begin : g_lsb
                assign shl_bit = 1'b0;
            end else begin : g_not_lsb
                assign shl_bit = d[gi-1];
            end

            // The MSB is where the two right shifts differ: zero-fill versus bit 0 wrapping in.
            if (gi == DATA_W - 1) begin : g_msb
                assign lsr_bit = 1'b0;
                assign ror_bit = d[0];
            end else begin : g_not_msb
                assign lsr_bit = d[gi+1];
                assign ror_bit = d[gi+1];
            end

            assign q[gi] = (op == SH_LSL) ? shl_bit :
                           (op == SH_LSR) ? lsr_bit :
                           (op == SH_ROR) ? ror_bit :
                                            d[gi];
        end
    endgenerate

endmodule

// File: rtl/shift_sequencer.sv
// Multi-bit shift controller: accepts one request, applies shift_step once per clock
// for the requested amount, then holds the result. Optional macro: SHIFT_EARLY_ZERO_EN.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int AMT_W  = DEF_AMT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_shift,
    input  logic [AMT_W-1:0]  in_amt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);

    state_t             state_reg, state_next;
    logic [DATA_W-1:0]  data_reg,  data_next;
    logic [AMT_W-1:0]   cnt_reg,   cnt_next;
    shift_op_t          op_reg,    op_next;
    logic [DATA_W-1:0]  step_q;

    shift_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .d  (data_reg),
        .op (op_reg),
        .q  (step_q)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            data_reg  <= '0;
            cnt_reg   <= '0;
            op_reg    <= SH_PASS;
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
            cnt_reg   <= cnt_next;
            op_reg    <= op_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        cnt_next   = cnt_reg;
        op_next    = op_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;

        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data_next = in_data;
                    op_next   = shift_op_t'(in_shift);
                    cnt_next  = in_amt;
                    // Nothing to iterate for a pass or a zero amount: result is the operand.
                    if ((in_amt == '0) || (shift_op_t'(in_shift) == SH_PASS)) begin
                        state_next = DONE;
                    end else begin
                        state_next = SHIFT;
                    end
                end
            end

            SHIFT: begin
                busy      = 1'b1;
                data_next = step_q;
                cnt_next  = cnt_reg - AMT_W'(1);
                if (cnt_reg == AMT_W'(1)) begin
                    state_next = DONE;
                end
`ifdef SHIFT_EARLY_ZERO_EN
                // Once a zero-filling shift reaches zero, further steps cannot change it.
                if (is_zero_fill(op_reg) && (step_q == '0)) begin
                    state_next = DONE;
                    cnt_next   = '0;
                end
`endif
            end

            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign out_data = data_reg;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed, table-driven bench for shift_sequencer with hand-written backpressure
// and mid-operation reset sequences.
module tb_shift_sequencer;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [1:0]  in_shift;
    logic [3:0]  in_amt;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        busy;

    int total;
    int bad;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  op;
        logic [3:0]  amt;
        logic [15:0] exp_data;
        int          exp_lat;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs [NVEC];

    shift_sequencer #(
        .DATA_W (16),
        .AMT_W  (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shift  (in_shift),
        .in_amt    (in_amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one request and wait for its result; expects to be called just after a posedge.
    // Latency counts accept edge k as 1, so out_valid after edge k+amt gives amt+1.
    task automatic run_req(input vec_t v, input int idx, output int lat);
        check("in_ready_before", 32'(in_ready), 32'd1);
        in_data  = v.data;
        in_shift = v.op;
        in_amt   = v.amt;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 16'h0;
        check("busy_after_accept", 32'(busy), 32'd1);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(v.exp_lat));
        check("out_data", 32'(out_data), 32'(v.exp_data));
        $display("txn %0d op=%0d in=%h amt=%0d -> out=%h lat=%0d", idx, v.op, v.data, v.amt, out_data, lat);
    endtask

    initial begin
        int lat;
        total     = 0;
        bad       = 0;
        reset_n   = 1'b1;
        in_valid  = 1'b0;
        in_data   = 16'h0;
        in_shift  = 2'b00;
        in_amt    = 4'd0;
        out_ready = 1'b1;

        vecs[0] = '{16'h0001, 2'b01, 4'd4,  16'h0010, 5};
        vecs[1] = '{16'h8001, 2'b11, 4'd1,  16'hC000, 2};
        vecs[2] = '{16'h0001, 2'b11, 4'd15, 16'h0002, 16};
        vecs[3] = '{16'h1234, 2'b00, 4'd9,  16'h1234, 1};
        vecs[4] = '{16'hF000, 2'b10, 4'd15, 16'h0001, 16};
        vecs[5] = '{16'hABCD, 2'b10, 4'd0,  16'hABCD, 1};
        vecs[6] = '{16'h1234, 2'b01, 4'd3,  16'h91A0, 4};
        vecs[7] = '{16'h1234, 2'b11, 4'd4,  16'h4123, 5};
        vecs[8] = '{16'h8421, 2'b10, 4'd5,  16'h0421, 6};
`ifdef SHIFT_EARLY_ZERO_EN
        vecs[9] = '{16'h8000, 2'b01, 4'd15, 16'h0000, 2};
`else
        vecs[9] = '{16'h8000, 2'b01, 4'd15, 16'h0000, 16};
`endif

        #1 reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            run_req(vecs[i], i, lat);
            @(posedge clk);
            #1;
            check("idle_in_ready_after", 32'(in_ready),  32'd1);
            check("idle_out_valid_after", 32'(out_valid), 32'd0);
        end

        // Backpressure: result must stay put and stray requests must be ignored.
        out_ready = 1'b0;
        run_req('{16'h00FF, 2'b01, 4'd8, 16'hFF00, 9}, 100, lat);
        for (int s = 0; s < 3; s++) begin
            in_valid = 1'b1;
            in_data  = 16'h5555;
            in_shift = 2'b01;
            in_amt   = 4'd1;
            @(posedge clk);
            #1;
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_out_data",  32'(out_data),  32'hFF00);
            check("stall_in_ready",  32'(in_ready),  32'd0);
            check("stall_busy",      32'(busy),      32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_out_valid", 32'(out_valid), 32'd0);
        check("release_in_ready",  32'(in_ready),  32'd1);
        check("release_data_kept", 32'(out_data),  32'hFF00);
        $display("txn 101 backpressure release out=%h", out_data);

        // Asynchronous reset three shift cycles into a long request.
        in_data  = 16'hFFFF;
        in_shift = 2'b10;
        in_amt   = 4'd10;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check("mid_busy_before_rst", 32'(busy), 32'd1);
        check("mid_data_before_rst", 32'(out_data), 32'h1FFF);
        reset_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_data",  32'(out_data),  32'd0);
        check("arst_in_ready",  32'(in_ready),  32'd1);
        check("arst_busy",      32'(busy),      32'd0);
        $display("txn 102 async reset mid-shift out=%h", out_data);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        run_req(vecs[0], 103, lat);
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Multi-bit shift controller for the 16-bit single-step shift datapath. Accepts one request (operand, shift code, amount) over a valid/ready handshake. Applies the 1-bit shift operation once per clock until the requested amount is done, then holds the result on a valid/ready output port. Sits between the datapath control FSM and the shifter stage, so the 1-bit shifter can implement N-bit shifts.

Parameters:
DATA_W, 16, operand/result width
AMT_W, 4, shift-amount width (max amount 2**AMT_W-1)

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  request present
in_ready  out  1  block can accept a request
in_data  in  DATA_W  operand
in_shift  in  2  op code: 00 pass, 01 shift left (0-fill), 10 logical shift right (0-fill), 11 rotate right by 1 (bit0 into MSB)
in_amt  in  AMT_W  number of single-bit steps
out_valid  out  1  result available
out_ready  in  1  consumer takes result
out_data  out  DATA_W  result
busy  out  1  high in SHIFT or DONE

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset (async, any state including mid-shift):
  - state=IDLE, data_q=0, cnt_q=0, op_q=00.
  - in_ready=1, out_valid=0, out_data=0, busy=0.
  - An in-flight request is discarded.
- States: IDLE, SHIFT, DONE. Encoding is local; no other outputs are registered.
- IDLE:
  - in_ready=1.
  - On in_valid at the edge (accept): data_q<=in_data, op_q<=in_shift, cnt_q<=in_amt.
  - If in_amt==0 or in_shift==00, go to DONE (data unchanged). Otherwise go to SHIFT.
- SHIFT:
  - Each edge: data_q<=step(data_q, op_q), cnt_q<=cnt_q-1.
  - When cnt_q==1 at the edge, go to DONE.
  - in_ready=0. in_valid is ignored.
- DONE:
  - out_valid=1, out_data=data_q, held stable while out_ready=0.
  - On out_ready at the edge, go to IDLE.
  - No same-cycle accept of a new request: in_ready=0 in DONE.
- Latency:
  - Accept edge k gives out_valid high in the cycle after edge k+amt (amt>0, op!=00).
  - Pass or amt==0 gives out_valid in the cycle after edge k.
  - Throughput: one request per amt+2 cycles with out_ready held high.
- out_data equals data_q in all states; only meaningful while out_valid=1.
- step() is combinational, one bit per op:
  - shl: {d[W-2:0],0}
  - lsr: {0,d[W-1:1]}
  - ror: {d[0],d[W-1:1]}
  - 00: d
- No arithmetic overflow flag. Left shifts discard MSBs silently.
- cnt_q never wraps: it only decrements in SHIFT, where cnt_q>=1.

Optional Feature:
SHIFT_EARLY_ZERO_EN
- Defined: in SHIFT with op_q==01 or 10, if step(data_q)==0 the block goes to DONE at that edge regardless of cnt_q; cnt_q is cleared to 0. Rotate (11) never terminates early.
- Undefined: always exactly amt SHIFT cycles.
- The result value is identical in both builds. Only latency differs.

Decomposition:
- Package shift_seq_pkg holds:
  - typedef enum logic[1:0] shift_op_t {SH_PASS, SH_LSL, SH_LSR, SH_ROR}
  - typedef enum state_t {IDLE, SHIFT, DONE}
  - DATA_W/AMT_W default localparams
- One sub-module, shift_step: combinational 1-bit shift unit with the same op encoding. The FSM, counter and handshake stay in shift_sequencer.

Test Plan:
1. shl 0x0001, amt 4, out_ready=1 -> out_data=0x0010; out_valid in cycle after edge k+4; then in_ready=1 next cycle.
2. ror 0x8001, amt 1 -> 0xC000. ror 0x0001, amt 15 -> 0x0002. pass 0x1234, amt 9 -> 0x1234 with latency 1.
3. lsr 0xF000, amt 15 -> 0x0001. lsr 0xABCD, amt 0 -> 0xABCD, latency 1.
4. Backpressure: shl 0x00FF, amt 8, out_ready=0 for 3 cycles -> out_data=0xFF00 stable, out_valid=1, in_ready=0 throughout; in_valid pulses during the stall are not accepted.
5. Reset mid-operation: lsr 0xFFFF, amt 10, reset_n low after 3 SHIFT cycles (asynchronously, between edges) -> immediately out_valid=0, out_data=0, in_ready=1, busy=0. The next request completes normally.
6. SHIFT_EARLY_ZERO_EN defined: shl 0x8000, amt 15 -> 0x0000 with out_valid after edge k+1. Undefined: same result after edge k+15.
